// File: rtl/pkt_tx_arbiter.sv
// pkt_tx_arbiter: shares one outgoing packet buffer between two
// byte-stream writers, granting whole transactions and committing lengths.
module pkt_tx_arbiter #(
   parameter int AW      = 9,
   parameter int MAX_LEN = 511
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_write,
   input  logic          a_strobe,
   input  logic [7:0]    a_data,
   output logic          a_success,
   input  logic          b_write,
   input  logic          b_strobe,
   input  logic [7:0]    b_data,
   output logic          b_success,
   output logic          buf_we,
   output logic [AW-1:0] buf_addr,
   output logic [7:0]    buf_data,
   output logic          buf_commit,
   output logic [AW-1:0] buf_len,
   input  logic          buf_release,
   output logic          busy,
   output logic [1:0]    owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          full;
   logic [AW-1:0] count;
   logic          overflow;
   logic          rr;
   logic          a_write_d;
   logic          b_write_d;
   logic          a_armed;
   logic          b_armed;

   logic          a_start;
   logic          b_start;
   logic          idle_ok;
   logic          grant_a;
   logic          grant_b;
   logic          rej_a;
   logic          rej_b;
   logic          a_end;
   logic          b_end;
   logic          own_wr;
   logic [7:0]    own_data;
   logic          commit_ok;

   // A requester holding write through reset is not armed until it drops write.
   assign a_start   = a_write & ~a_write_d & a_armed;
   assign b_start   = b_write & ~b_write_d & b_armed;
   assign idle_ok   = (state == IDLE) & ~full;
   assign grant_a   = idle_ok & a_start & (~b_start | ~rr);
   assign grant_b   = idle_ok & b_start & (~a_start | rr);
   assign rej_a     = a_start & ~grant_a;
   assign rej_b     = b_start & ~grant_b;
   assign a_end     = (state == OWN_A) & ~a_write;
   assign b_end     = (state == OWN_B) & ~b_write;
   assign own_wr    = ((state == OWN_A) & a_write & a_strobe) |
                      ((state == OWN_B) & b_write & b_strobe);
   assign own_data  = (state == OWN_B) ? b_data : a_data;
   assign commit_ok = (a_end | b_end) & (count != '0) & ~overflow;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: grant whole transactions, return to IDLE on owner write fall.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_a)      state_nxt = OWN_A;
            else if (grant_b) state_nxt = OWN_B;
         end
         OWN_A:   if (!a_write) state_nxt = IDLE;
         OWN_B:   if (!b_write) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs derived from the state register and full flag.
   always_comb begin
      owner = state;
      busy  = (state != IDLE) | full;
   end

   // Datapath: byte writes, commit, full flag, success flags, rr pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_write_d  <= 1'b0;
         b_write_d  <= 1'b0;
         a_armed    <= 1'b0;
         b_armed    <= 1'b0;
         full       <= 1'b0;
         count      <= '0;
         overflow   <= 1'b0;
         rr         <= 1'b0;
         a_success  <= 1'b0;
         b_success  <= 1'b0;
         buf_we     <= 1'b0;
         buf_addr   <= '0;
         buf_data   <= '0;
         buf_commit <= 1'b0;
         buf_len    <= '0;
      end else begin
         a_write_d  <= a_write;
         b_write_d  <= b_write;
         a_armed    <= a_armed | ~a_write;
         b_armed    <= b_armed | ~b_write;
         buf_we     <= 1'b0;
         buf_commit <= 1'b0;

         if (grant_a | grant_b) begin
            count    <= '0;
            overflow <= 1'b0;
         end

         if (idle_ok & a_start & b_start) rr <= ~rr;

         if (own_wr) begin
            if (count < AW'(MAX_LEN)) begin
               buf_we   <= 1'b1;
               buf_addr <= count;
               buf_data <= own_data;
               count    <= count + AW'(1);
            end else begin
               overflow <= 1'b1;
            end
         end

         if (commit_ok) begin
            buf_commit <= 1'b1;
            buf_len    <= count;
            full       <= 1'b1;
         end else if (buf_release) begin
            full <= 1'b0;
         end

         if (grant_a | rej_a) a_success <= 1'b0;
         else if (a_end)      a_success <= commit_ok;

         if (grant_b | rej_b) b_success <= 1'b0;
         else if (b_end)      b_success <= commit_ok;
      end
   end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// tb_pkt_tx_arbiter: directed/random transactions checked against a
// transaction-level model of buffer ownership, writes and commits.
module tb_pkt_tx_arbiter;
   localparam int AW      = 9;
   localparam int MAX_LEN = 511;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_write, a_strobe, b_write, b_strobe;
   logic [7:0]    a_data, b_data;
   logic          a_success, b_success;
   logic          buf_we, buf_commit, buf_release, busy;
   logic [AW-1:0] buf_addr, buf_len;
   logic [7:0]    buf_data;
   logic [1:0]    owner;

   pkt_tx_arbiter #(.AW(AW), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_write(a_write), .a_strobe(a_strobe), .a_data(a_data),
      .a_success(a_success),
      .b_write(b_write), .b_strobe(b_strobe), .b_data(b_data),
      .b_success(b_success),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
      .buf_commit(buf_commit), .buf_len(buf_len),
      .buf_release(buf_release), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   wr_t got_q[$];
   int  exp_len[$];
   int  got_len[$];

   // Monitor: record every buffer write and commit.
   always @(negedge clk) begin
      if (buf_we)
         got_q.push_back('{cyc, int'(buf_addr), int'(buf_data)});
      if (buf_commit)
         got_len.push_back(int'(buf_len));
   end

   int n_chk  = 0;
   int n_fail = 0;

   // Model: 0 = none, 1 = A, 2 = B
   int m_own;
   bit m_full;
   int m_cnt;
   bit m_ovf;
   bit m_succ[2];
   int m_rr;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_write(int x, logic v);
      if (x == 0) a_write = v;
      else        b_write = v;
   endtask

   task automatic model_reset();
      m_own   = 0;
      m_full  = 0;
      m_cnt   = 0;
      m_ovf   = 0;
      m_succ[0] = 0;
      m_succ[1] = 0;
      m_rr    = 0;
   endtask

   task automatic grant(int x);
      m_own     = x + 1;
      m_cnt     = 0;
      m_ovf     = 0;
      m_succ[x] = 0;
   endtask

   task automatic do_start(int x);
      set_write(x, 1'b1);
      if (!m_full && m_own == 0) grant(x);
      else                       m_succ[x] = 0;
      tick();
   endtask

   task automatic do_both();
      int w;
      a_write = 1'b1;
      b_write = 1'b1;
      if (!m_full && m_own == 0) begin
         w = m_rr;
         grant(w);
         m_succ[1-w] = 0;
         m_rr = 1 - w;
      end else begin
         m_succ[0] = 0;
         m_succ[1] = 0;
      end
      tick();
   endtask

   task automatic do_byte(int x, int d, int gap);
      logic wr;
      wr = (x == 0) ? a_write : b_write;
      if (x == 0) begin a_strobe = 1'b1; a_data = 8'(d); end
      else        begin b_strobe = 1'b1; b_data = 8'(d); end
      if (m_own == x + 1 && wr) begin
         if (m_cnt < MAX_LEN) begin
            exp_q.push_back('{cyc + 1, m_cnt, d & 255});
            m_cnt++;
         end else begin
            m_ovf = 1;
         end
      end
      tick();
      a_strobe = 1'b0;
      b_strobe = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic model_end(int x);
      if (m_own == x + 1) begin
         if (m_cnt > 0 && !m_ovf) begin
            exp_len.push_back(m_cnt);
            m_succ[x] = 1;
            m_full = 1;
         end else begin
            m_succ[x] = 0;
         end
         m_own = 0;
      end
   endtask

   task automatic do_end(int x);
      set_write(x, 1'b0);
      model_end(x);
      tick();
   endtask

   task automatic do_release();
      buf_release = 1'b1;
      m_full = 0;
      tick();
      buf_release = 1'b0;
   endtask

   task automatic check_all(string tag);
      int n;
      @(negedge clk);
      #1;
      chk({tag, "_nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_cyc"},  got_q[i].c,    exp_q[i].c);
         chk({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
         chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      end
      chk({tag, "_ncommit"}, got_len.size(), exp_len.size());
      n = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
      for (int i = 0; i < n; i++)
         chk({tag, "_len"}, got_len[i], exp_len[i]);
      got_q.delete();
      exp_q.delete();
      got_len.delete();
      exp_len.delete();
      chk({tag, "_a_success"}, a_success, m_succ[0]);
      chk({tag, "_b_success"}, b_success, m_succ[1]);
      chk({tag, "_owner"}, owner, (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00);
      chk({tag, "_busy"}, busy, (m_own != 0) || m_full);
   endtask

   task automatic chk_reset_outs(string tag);
      chk({tag, "_we"},     buf_we, 1'b0);
      chk({tag, "_addr"},   buf_addr, '0);
      chk({tag, "_data"},   buf_data, 8'h00);
      chk({tag, "_commit"}, buf_commit, 1'b0);
      chk({tag, "_len"},    buf_len, '0);
      chk({tag, "_asucc"},  a_success, 1'b0);
      chk({tag, "_bsucc"},  b_success, 1'b0);
      chk({tag, "_busy"},   busy, 1'b0);
      chk({tag, "_owner"},  owner, 2'b00);
   endtask

   initial begin
      int n;
      rst_n       = 1'b0;
      a_write     = 1'b0;
      a_strobe    = 1'b0;
      a_data      = 8'h00;
      b_write     = 1'b0;
      b_strobe    = 1'b0;
      b_data      = 8'h00;
      buf_release = 1'b0;
      model_reset();
      repeat (3) tick();
      chk_reset_outs("reset");
      rst_n = 1'b1;
      tick();

      // Basic A transaction
      do_start(0);
      check_all("s1_grant");
      do_byte(0, 'h11, $urandom_range(0, 2));
      do_byte(0, 'h22, $urandom_range(0, 2));
      do_byte(0, 'h33, $urandom_range(0, 2));
      do_end(0);
      check_all("s1_commit");
      repeat (3) tick();
      chk("s1_busy_hold", busy, 1'b1);
      do_release();
      check_all("s1_release");

      // Random-length B transaction; A's flag untouched
      do_start(1);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
         do_byte(1, $urandom_range(0, 255), $urandom_range(0, 1));
      do_end(1);
      check_all("b_rand");
      do_release();

      // Simultaneous start: A wins first, then B
      do_both();
      check_all("s2_grant_a");
      do_byte(1, $urandom_range(0, 255), 0);
      do_byte(1, $urandom_range(0, 255), 0);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
         do_byte(0, $urandom_range(0, 255), $urandom_range(0, 2));
      do_end(1);
      do_end(0);
      check_all("s2_commit_a");
      do_release();
      do_both();
      check_all("s2_grant_b");
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
         do_byte(1, $urandom_range(0, 255), 0);
         do_byte(0, $urandom_range(0, 255), 0);
      end
      do_end(0);
      do_end(1);
      check_all("s2_commit_b");

      // Buffer full: B rejected
      do_start(1);
      do_byte(1, $urandom_range(0, 255), 0);
      do_byte(1, $urandom_range(0, 255), 1);
      do_end(1);
      check_all("s3_full_rej");
      do_release();
      do_start(1);
      do_byte(1, $urandom_range(0, 255), 0);
      do_end(1);
      check_all("s3_one_byte");
      do_release();

      // Overflow: MAX_LEN+1 bytes
      do_start(0);
      for (int i = 0; i < MAX_LEN + 1; i++)
         do_byte(0, $urandom_range(0, 255), 0);
      do_end(0);
      check_all("s4_overflow");

      // Zero-strobe pulse after a success
      do_start(0);
      do_byte(0, $urandom_range(0, 255), 0);
      do_end(0);
      do_release();
      check_all("s5_pre");
      do_start(0);
      do_end(0);
      check_all("s5_empty");

      // Reset mid-transaction, A holds write through reset
      do_start(0);
      do_byte(0, $urandom_range(0, 255), 0);
      do_byte(0, $urandom_range(0, 255), $urandom_range(0, 1));
      rst_n = 1'b0;
      tick();
      model_reset();
      chk_reset_outs("s6_rst");
      check_all("s6_rst_q");
      rst_n = 1'b1;
      repeat (2) tick();
      do_byte(0, $urandom_range(0, 255), 0);
      do_byte(0, $urandom_range(0, 255), 0);
      check_all("s6_held");
      set_write(0, 1'b0);
      tick();
      do_start(0);
      do_byte(0, $urandom_range(0, 255), 0);
      do_end(0);
      check_all("s6_toggle");
      do_release();

      // B owns while A starts; B ends as A restarts
      do_start(0);
      do_byte(0, $urandom_range(0, 255), 0);
      do_end(0);
      do_release();
      do_start(1);
      do_start(0);
      check_all("s7_a_rej");
      set_write(0, 1'b0);
      tick();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
         do_byte(1, $urandom_range(0, 255), $urandom_range(0, 1));
      b_write = 1'b0;
      a_write = 1'b1;
      model_end(1);
      m_succ[0] = 0;
      tick();
      check_all("s7_swap");
      do_release();
      check_all("s7_release");
      a_write = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_tx_arbiter.md
Name: pkt_tx_arbiter

Overview:
- Shares the single outgoing UDP packet buffer between two byte-stream writers.
  - Requester A: microcontroller SPI path.
  - Requester B: local FPGA packet generator.
- Each requester uses the same transaction interface: write level held for the whole transaction, single-cycle strobe per data byte, sticky success flag read back afterwards.
- Grants whole transactions, writes bytes into the buffer with sequential addresses and commits the packet length.
- Rejects contending transactions and holds the buffer until the transmitter releases it.

Parameters:
- AW, 9, buffer address and length width.
- MAX_LEN, 511, maximum accepted bytes per packet (must be ≤ 2^AW−1).

Ports:
- clk  in  1  system clock (Ethernet domain); single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- a_write  in  1  requester A transaction active (level).
- a_strobe  in  1  requester A data byte valid (one cycle).
- a_data  in  8  requester A data byte.
- a_success  out  1  A's last transaction committed.
- b_write  in  1  requester B transaction active.
- b_strobe  in  1  requester B byte valid.
- b_data  in  8  requester B byte.
- b_success  out  1  B's last transaction committed.
- buf_we  out  1  buffer write enable.
- buf_addr  out  AW  buffer write address.
- buf_data  out  8  buffer write data.
- buf_commit  out  1  single-cycle packet-complete pulse.
- buf_len  out  AW  committed length, valid from buf_commit until next commit.
- buf_release  in  1  single-cycle pulse from transmitter; buffer drained.
- busy  out  1  state ≠ IDLE, or buffer full.
- owner  out  2  one-hot current grant {B,A}; 0 when idle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE, full=0, count=0, overflow=0, rr pointer favours A.
  - All outputs 0.
  - Reset mid-transaction discards the partial packet; no buf_commit is issued.
- Per-requester start event: write_x & ~write_x_d, with write_x_d registered and reset to 0.
  - A requester whose write is already high when it becomes eligible is never granted; it must drop write and reassert.
- State IDLE:
  - Start event from exactly one requester and full=0 → OWN_x.
  - Both requesters start in the same cycle → rr winner gets the grant; the rr pointer then favours the other requester.
  - Entry to OWN_x: count=0, overflow=0, success_x←0.
- Rejection: a start event that is not granted forces success_x←0 on the next cycle, no data is written, and the requester's strobes are ignored until its next start event. Rejection applies to:
  - a start while full=1,
  - a start while the other requester owns the buffer,
  - the losing requester of a simultaneous start.
- State OWN_x, each owner strobe with write_x=1:
  - count < MAX_LEN: next cycle buf_we=1, buf_addr=count, buf_data=data; then count←count+1.
  - count == MAX_LEN: overflow←1, byte dropped, no buf_we.
  - Strobes while write_x=0, and all strobes from the non-owner, are ignored.
- Owner write falling edge, evaluated in the cycle write_x is first seen low:
  - count>0 and overflow=0: next cycle buf_commit=1, buf_len=count, success_x←1, full←1 → IDLE.
  - Otherwise: no commit, success_x←0 → IDLE.
  - A new start by the other requester in the cycle the owner ends is rejected, because the state is not yet IDLE.
- full:
  - Cleared by buf_release; buf_release while full=0 is ignored.
  - While full=1, IDLE grants nothing.
  - buf_release in the same cycle as a start event: the start is rejected (full is sampled before clear).
- Latency: strobe → buf_we is 1 cycle; write fall → buf_commit is 1 cycle.
- Sticky flags: success flags hold value between events. The opposite requester's flag is unaffected by its peer's activity except by its own start or rejection.
- busy = (state≠IDLE) | full. owner reflects the state register.

Test Plan:
- A start, 3 strobes (0x11,0x22,0x33), write fall → buf_we at addr 0,1,2 with those data, one cycle after each strobe; buf_commit with buf_len=3; a_success=1; busy stays 1 until buf_release pulse, then 0.
- A and B start on the same cycle after reset → A granted (owner=01), b_success=0, B strobes produce no buf_we. Repeat after release → B granted.
- Buffer full, B start, 2 strobes, fall → no buf_we, no commit, b_success=0. After buf_release, a fresh B start of 1 byte commits with buf_len=1.
- A sends MAX_LEN+1 bytes (512 with defaults) → 511 buf_we writes (addr 0..510), no commit, a_success=0, full stays 0.
- A write pulse with zero strobes → no commit, a_success=0. rst_n low mid-transaction after 2 bytes → no commit, all outputs 0; A holding write high after reset is not granted until it toggles write.
- B owns the buffer while A starts → a_success=0. B ends in the same cycle A starts again → A is still rejected; B commits.
